// File: rtl/z_pkg.sv
// z_pkg: shared definitions for the Processor-Z execution core.
//   - default widths (ADDR_W_DEF, DATA_W_DEF, NREG_DEF) and register-specifier width
//   - {icode,ifun} opcode constants and instruction field positions
//   - internal ALU operation encoding and the opcode decoder
package z_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 8;
    localparam int REG_W      = 4;

    // {icode,ifun} values
    localparam logic [7:0] IRMOV = 8'h10;
    localparam logic [7:0] ADD   = 8'h20;
    localparam logic [7:0] SUB   = 8'h21;
    localparam logic [7:0] AND   = 8'h22;
    localparam logic [7:0] XOR   = 8'h23;
    localparam logic [7:0] NOP   = 8'h00;

    // Instruction field slices
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int RA_MSB   = 23;
    localparam int RA_LSB   = 20;
    localparam int RB_MSB   = 19;
    localparam int RB_LSB   = 16;
    localparam int VALC_MSB = 15;
    localparam int VALC_LSB = 0;

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_MOV  = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_XOR  = 3'd5
    } aluOp_e;

    // Anything not listed is a NOP: no register write.
    function automatic aluOp_e decodeOp(input logic [7:0] code);
        aluOp_e op;
        case (code)
            IRMOV:   op = ALU_MOV;
            ADD:     op = ALU_ADD;
            SUB:     op = ALU_SUB;
            AND:     op = ALU_AND;
            XOR:     op = ALU_XOR;
            NOP:     op = ALU_NONE;
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/z_regfile.sv
// z_regfile: NREG x DATA_W register file for the Processor-Z core.
//   clock    in   rising-edge clock
//   reset    in   synchronous active-low clear of all registers
//   rdAddrA  in   read port A specifier (4 bits; >= NREG reads 0)
//   rdAddrB  in   read port B specifier
//   rdDataA  out  read port A data (combinational, write-through)
//   rdDataB  out  read port B data
//   wrEn     in   write enable
//   wrAddr   in   write specifier (>= NREG is discarded)
//   wrData   in   write data
//   regsFlat out  registers r0..r7 packed, r0 in the low lane
module z_regfile
    import z_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_W-1:0]    rdAddrA,
    input  logic [REG_W-1:0]    rdAddrB,
    output logic [DATA_W-1:0]   rdDataA,
    output logic [DATA_W-1:0]   rdDataB,
    input  logic                wrEn,
    input  logic [REG_W-1:0]    wrAddr,
    input  logic [DATA_W-1:0]   wrData,
    output logic [8*DATA_W-1:0] regsFlat
);

    localparam int                IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [REG_W-1:0]  NREG_L = REG_W'(NREG);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && (wrAddr < NREG_L)) begin
            regs[wrAddr[IDX_W-1:0]] <= wrData;
        end
    end

    // Write-through: a read of the register being written this cycle sees
    // the incoming value, so a reader two slots behind a producer is safe.
    assign rdDataA = (rdAddrA >= NREG_L)                ? '0     :
                     (wrEn && (wrAddr == rdAddrA))      ? wrData :
                                                          regs[rdAddrA[IDX_W-1:0]];
    assign rdDataB = (rdAddrB >= NREG_L)                ? '0     :
                     (wrEn && (wrAddr == rdAddrB))      ? wrData :
                                                          regs[rdAddrB[IDX_W-1:0]];

    for (genvar i = 0; i < 8; i++) begin : gLane
        if (i < NREG) begin : gLive
            assign regsFlat[i*DATA_W +: DATA_W] = regs[i];
        end else begin : gZero
            assign regsFlat[i*DATA_W +: DATA_W] = '0;
        end
    end

endmodule

// File: rtl/z_pipe_core.sv
// z_pipe_core: Processor-Z execution core. 512x32 instruction RAM with a host
// load port, 8x32 register file and a 4-stage in-order pipeline
// (Fetch, Decode, Execute, Write-back) running IRMOV/ADD/SUB/AND/XOR.
//   clock    in   rising-edge clock
//   reset    in   synchronous active-low reset (PC, pipeline, registers; RAM kept)
//   addr     in   host load address (load mode)
//   wr       in   host write strobe (load mode only)
//   wdata    in   host write data
//   working  in   1 = run pipeline, 0 = load mode with pipeline frozen
//   valA     out  Decode-stage rA operand
//   valB     out  Decode-stage rB operand
//   r0..r7   out  live register contents
// Build option: define Z_FORWARD_EN to bypass Execute and Write-back results
// into the Decode-stage operands.
module z_pipe_core
    import z_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              working,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7
);

    localparam logic [REG_W-1:0] NREG_L = REG_W'(NREG);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] ramAddr;
    logic [ADDR_W-1:0] pc;

    // F register: fetched instruction word (0 = bubble)
    logic [DATA_W-1:0] fInstr;

    // Decode outputs from the F register
    aluOp_e            fOp;
    logic [REG_W-1:0]  fRa;
    logic [REG_W-1:0]  fRb;
    logic [DATA_W-1:0] fValC;
    logic [DATA_W-1:0] rfA;
    logic [DATA_W-1:0] rfB;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;

    // D register: decoded instruction consumed by Execute
    aluOp_e            dOp;
    logic [REG_W-1:0]  dDst;
    logic [DATA_W-1:0] dValA;
    logic [DATA_W-1:0] dValB;
    logic [DATA_W-1:0] dValC;

    // Execute-stage combinational result
    logic              exWen;
    logic [DATA_W-1:0] exResult;

    // E register: result consumed by Write-back
    logic              eWen;
    logic [REG_W-1:0]  eDst;
    logic [DATA_W-1:0] eResult;

    logic [8*DATA_W-1:0] regsFlat;

    // In run mode the single RAM port follows the PC; host address otherwise.
    assign ramAddr = working ? pc : addr;

    always_ff @(posedge clock) begin
        if (reset && !working && wr) begin
            mem[ramAddr] <= wdata;
        end
    end

    assign fOp   = decodeOp(fInstr[OP_MSB:OP_LSB]);
    assign fRa   = fInstr[RA_MSB:RA_LSB];
    assign fRb   = fInstr[RB_MSB:RB_LSB];
    assign fValC = {{(DATA_W-16){1'b0}}, fInstr[VALC_MSB:VALC_LSB]};

    z_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) uRegfile (
        .clock    (clock),
        .reset    (reset),
        .rdAddrA  (fRa),
        .rdAddrB  (fRb),
        .rdDataA  (rfA),
        .rdDataB  (rfB),
        .wrEn     (working && eWen),
        .wrAddr   (eDst),
        .wrData   (eResult),
        .regsFlat (regsFlat)
    );

    always_comb begin
        exResult = '0;
        case (dOp)
            ALU_MOV: exResult = dValC;
            ALU_ADD: exResult = dValB + dValA;
            ALU_SUB: exResult = dValB - dValA;
            ALU_AND: exResult = dValB & dValA;
            ALU_XOR: exResult = dValB ^ dValA;
            default: exResult = '0;
        endcase
    end

    // A write to a specifier >= NREG is dropped, so it must never be bypassed.
    assign exWen = (dOp != ALU_NONE) && (dDst < NREG_L);

`ifdef Z_FORWARD_EN
    // Write-back result first, then Execute result overrides it: the
    // youngest producer wins.
    always_comb begin
        opA = rfA;
        opB = rfB;
        if (eWen && (eDst == fRa)) opA = eResult;
        if (eWen && (eDst == fRb)) opB = eResult;
        if (exWen && (dDst == fRa)) opA = exResult;
        if (exWen && (dDst == fRb)) opB = exResult;
    end
`else
    assign opA = rfA;
    assign opB = rfB;
`endif

    assign valA = opA;
    assign valB = opB;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc      <= '0;
            fInstr  <= '0;
            dOp     <= ALU_NONE;
            dDst    <= '0;
            dValA   <= '0;
            dValB   <= '0;
            dValC   <= '0;
            eWen    <= 1'b0;
            eDst    <= '0;
            eResult <= '0;
        end else if (working) begin
            pc      <= pc + ADDR_W'(1);
            fInstr  <= mem[ramAddr];
            dOp     <= fOp;
            dDst    <= fRb;
            dValA   <= opA;
            dValB   <= opB;
            dValC   <= fValC;
            eWen    <= exWen;
            eDst    <= dDst;
            eResult <= exResult;
        end
    end

    assign r0 = regsFlat[0*DATA_W +: DATA_W];
    assign r1 = regsFlat[1*DATA_W +: DATA_W];
    assign r2 = regsFlat[2*DATA_W +: DATA_W];
    assign r3 = regsFlat[3*DATA_W +: DATA_W];
    assign r4 = regsFlat[4*DATA_W +: DATA_W];
    assign r5 = regsFlat[5*DATA_W +: DATA_W];
    assign r6 = regsFlat[6*DATA_W +: DATA_W];
    assign r7 = regsFlat[7*DATA_W +: DATA_W];

endmodule

// File: tb/tb_z_pipe_core.sv
// tb_z_pipe_core: scoreboard bench for z_pipe_core. An instruction-set level
// model executes each instruction when it is fetched and queues the expected
// operands and architectural register state; a monitor pops and compares as
// the pipeline presents them.
module tb_z_pipe_core;

  localparam int W = 256;

  logic        clock;
  logic        reset;
  logic [8:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic [31:0] valA, valB;
  logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;

  z_pipe_core dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata),
    .working (working),
    .valA    (valA),
    .valB    (valB),
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3),
    .r4      (r4),
    .r5      (r5),
    .r6      (r6),
    .r7      (r7)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];   // register state after each instruction retires
  logic [63:0]  op_q[$];    // {valA, valB} expected while instruction is in Decode
  logic [W-1:0] lastExp;
  int           runEdges;

  // ---------------- reference model ----------------
  logic [31:0] modelMem [512];
  logic [31:0] modelReg [8];
  int          modelPc;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [W-1:0] dutRegs();
    return {r7, r6, r5, r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [W-1:0] modelRegs();
    return {modelReg[7], modelReg[6], modelReg[5], modelReg[4],
            modelReg[3], modelReg[2], modelReg[1], modelReg[0]};
  endfunction

  function automatic logic [31:0] rdReg(input logic [3:0] s);
    return (s < 4'd8) ? modelReg[s[2:0]] : 32'h0;
  endfunction

  task automatic wrReg(input logic [3:0] s, input logic [31:0] v);
    if (s < 4'd8) modelReg[s[2:0]] = v;
  endtask

  function automatic bit isLive(input logic [7:0] code);
    return code == 8'h10 || code == 8'h20 || code == 8'h21 || code == 8'h22 || code == 8'h23;
  endfunction

  // Execute the instruction at the model PC, as the ISA defines it.
  task automatic modelStep();
    logic [31:0] ins;
    logic [3:0]  ra, rb;
    logic [31:0] a, b;
    ins = modelMem[modelPc];
    ra  = ins[23:20];
    rb  = ins[19:16];
    a   = rdReg(ra);
    b   = rdReg(rb);
    op_q.push_back({a, b});
    case (ins[31:24])
      8'h10:   wrReg(rb, {16'h0, ins[15:0]});
      8'h20:   wrReg(rb, b + a);
      8'h21:   wrReg(rb, b - a);
      8'h22:   wrReg(rb, b & a);
      8'h23:   wrReg(rb, b ^ a);
      default: ;
    endcase
    exp_q.push_back(modelRegs());
    modelPc = (modelPc + 1) % 512;
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic loadWord(input int a, input logic [31:0] d);
    working = 1'b0;
    wr      = 1'b1;
    addr    = 9'(a);
    wdata   = d;
    @(posedge clock);
    modelMem[a] = d;
    @(negedge clock);
    wr = 1'b0;
  endtask

  task automatic runCycles(input int n);
    working = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      modelStep();
      @(negedge clock);
    end
  endtask

  task automatic freeze(input int n, input bit doWrite, input logic [8:0] a, input logic [31:0] d);
    working = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (doWrite && i == 0) begin
        wr = 1'b1; addr = a; wdata = d;
      end
      @(posedge clock);
      if (doWrite && i == 0) modelMem[a] = d;
      @(negedge clock);
      wr = 1'b0;
      check("freeze_regs", dutRegs(), lastExp);
    end
  endtask

  // First edge keeps working at runHigh, second presents a host write:
  // reset must win over both.
  task automatic doReset(input logic runHigh);
    reset   = 1'b0;
    working = runHigh;
    wr      = 1'b1;
    addr    = 9'd3;
    wdata   = 32'h10F3_ABCD;
    @(posedge clock);
    exp_q.delete();
    op_q.delete();
    @(negedge clock);
    working = 1'b0;
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 8; i++) modelReg[i] = 32'h0;
    modelPc = 0;
    check("reset_regs", dutRegs(), '0);
    check("reset_valA", valA, 32'h0);
    check("reset_valB", valB, 32'h0);
    reset = 1'b1;
    wr    = 1'b0;
  endtask

  // ---------------- random program generation ----------------
  function automatic logic [3:0] pickReg();
    int v;
    v = $urandom_range(0, 11);
    if (v >= 8) return 4'($urandom_range(8, 15));
    return 4'(v);
  endfunction

  function automatic logic [7:0] aluCode(input int i);
    case (i)
      0:       return 8'h20;
      1:       return 8'h21;
      2:       return 8'h22;
      default: return 8'h23;
    endcase
  endfunction

  function automatic logic [31:0] genWord();
    int          sel;
    logic [31:0] w;
    sel = $urandom_range(0, 9);
    if (sel < 3) begin
      w = {8'h10, pickReg(), pickReg(), 16'($urandom)};
    end else if (sel < 8) begin
      w = {aluCode($urandom_range(0, 3)), pickReg(), pickReg(), 16'($urandom)};
    end else begin
      w = $urandom;
      if (isLive(w[31:24])) w[31:28] = 4'h7;
    end
    return w;
  endfunction

  function automatic int dstOf(input logic [31:0] w);
    if (isLive(w[31:24]) && w[19:16] < 4'd8) return int'(w[19:16]);
    return -1;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [63:0]  e;
    logic [W-1:0] s;
    runEdges = 0;
    lastExp  = '0;
    forever begin
      @(posedge clock);
      if (reset === 1'b0) begin
        runEdges = 0;
        lastExp  = '0;
      end else if (working === 1'b1) begin
        runEdges++;
        #2;
        if (op_q.size() == 0) begin
          failNow("operand_queue_empty");
        end else begin
          e = op_q.pop_front();
          check("decode_valA", valA, e[63:32]);
          check("decode_valB", valB, e[31:0]);
        end
        if (runEdges >= 4) begin
          if (exp_q.size() == 0) begin
            failNow("retire_queue_empty");
          end else begin
            s = exp_q.pop_front();
            lastExp = s;
            check("retire_regs", dutRegs(), s);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int dstHist[3];
    reset   = 1'b1;
    wr      = 1'b0;
    working = 1'b0;
    addr    = '0;
    wdata   = '0;
    @(negedge clock);

    doReset(1'b0);

    // Directed program: IRMOV r0..r7, four ALU ops, zeros elsewhere.
    for (int a = 0; a < 512; a++) begin
      logic [31:0] w;
      if (a < 8)        w = 32'h10F0_0080 + 32'(a) * 32'h0001_0001;
      else if (a == 8)  w = 32'h2001_0000;
      else if (a == 9)  w = 32'h2123_0000;
      else if (a == 10) w = 32'h2245_0000;
      else if (a == 11) w = 32'h2367_0000;
      else              w = 32'h0;
      loadWord(a, w);
    end

    runCycles(5);
    freeze(3, 1'b1, 9'd0, 32'h10F0_FFFF);
    runCycles(20);

    check("alu_r0", r0, 32'h80);
    check("alu_r1", r1, 32'h101);
    check("alu_r2", r2, 32'h82);
    check("alu_r3", r3, 32'h1);
    check("alu_r4", r4, 32'h84);
    check("alu_r5", r5, 32'h84);
    check("alu_r6", r6, 32'h86);
    check("alu_r7", r7, 32'h1);

    // 516 run edges: address 0 refetched after the wrap has just retired.
    runCycles(491);
    check("wrap_r0", r0, 32'h0000_FFFF);
    check("wrap_r1", r1, 32'h101);

    // Reset while running, then a random hazard-free program after the IRMOVs.
    doReset(1'b1);
    dstHist[0] = 5; dstHist[1] = 6; dstHist[2] = 7;
    for (int k = 8; k < 72; k++) begin
      logic [31:0] w;
      bit ok;
      int tries;
      tries = 0;
      do begin
        w  = genWord();
        ok = 1'b1;
        for (int j = 0; j < 3; j++) begin
          if (int'(w[23:20]) == dstHist[j] || int'(w[19:16]) == dstHist[j]) ok = 1'b0;
        end
        // zeros after the program read r0
        if (k >= 69 && dstOf(w) == 0) ok = 1'b0;
        tries++;
      end while (!ok && tries < 200);
      if (!ok) w = 32'h70FF_0000;
      loadWord(k, w);
      dstHist[0] = dstHist[1];
      dstHist[1] = dstHist[2];
      dstHist[2] = dstOf(w);
    end

    for (int i = 0; i < 16; i++) begin
      runCycles($urandom_range(3, 12));
      freeze($urandom_range(1, 3), 1'($urandom_range(0, 1)),
             9'($urandom_range(300, 500)), $urandom);
    end
    runCycles(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
